// File: rtl/zynet_axil_master_if.sv
// AXI-lite bus between the zynet command master and a register slave.
// The master modport drives the address/data/valid side; the slave modport mirrors it.
interface zynet_axil_master_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/zynet_axil_master.sv
// zynet_axil_master: queues write / read / wait-for-interrupt commands in a small
// FIFO and executes them one at a time as AXI-lite transactions, returning one
// response per command.
// Optional feature: define ZYNET_AXIL_TIMEOUT_EN to add a per-transaction
// watchdog that aborts a stuck transaction after TIMEOUT_CYCLES cycles.
module zynet_axil_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [1:0]            rsp_op,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_err,
   input  logic                  intr,
   zynet_axil_master_if.master   m_axi
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, WAIT_INTR, RSP
   } state_t;

   state_t state, state_nxt;

   logic [1:0]            fifo_op    [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_addr  [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_wdata [FIFO_DEPTH];
   logic [PTR_W:0]        wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
   logic                  empty, full_nxt, push, pop;
   logic [1:0]            head_op;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [DATA_WIDTH-1:0] head_wdata;

   logic [1:0]            cur_op;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  aw_done, w_done;
   logic                  intr_q, intr_rise;
   logic                  timeout;

   assign empty      = (wr_ptr == rd_ptr);
   assign push       = cmd_valid && cmd_ready;
   assign pop        = (state == IDLE) && !empty;
   assign wr_ptr_nxt = wr_ptr + {{PTR_W{1'b0}}, push};
   assign rd_ptr_nxt = rd_ptr + {{PTR_W{1'b0}}, pop};
   // cmd_ready is registered from the post-update pointers, so it already
   // reflects this cycle's push; a pop only frees space visibly one cycle later.
   assign full_nxt   = (wr_ptr_nxt[PTR_W] != rd_ptr_nxt[PTR_W]) &&
                       (wr_ptr_nxt[PTR_W-1:0] == rd_ptr_nxt[PTR_W-1:0]);
   assign head_op    = fifo_op[rd_ptr[PTR_W-1:0]];
   assign head_addr  = fifo_addr[rd_ptr[PTR_W-1:0]];
   assign head_wdata = fifo_wdata[rd_ptr[PTR_W-1:0]];
   assign intr_rise  = intr && !intr_q;

   // FIFO pointers and registered ready
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cmd_ready <= 1'b0;
      end else begin
         wr_ptr    <= wr_ptr_nxt;
         rd_ptr    <= rd_ptr_nxt;
         cmd_ready <= !full_nxt;
      end
   end

   // FIFO storage; contents are only meaningful between the pointers
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_op[wr_ptr[PTR_W-1:0]]    <= cmd_op;
         fifo_addr[wr_ptr[PTR_W-1:0]]  <= cmd_addr;
         fifo_wdata[wr_ptr[PTR_W-1:0]] <= cmd_wdata;
      end
   end

   // Previous interrupt level for rising-edge detection
   always_ff @(posedge clock or posedge reset) begin
      if (reset) intr_q <= 1'b0;
      else       intr_q <= intr;
   end

`ifdef ZYNET_AXIL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_cnt;
   logic          busy;

   assign busy    = (state == WR) || (state == WR_RESP) || (state == RD_ADDR) ||
                    (state == RD_DATA) || (state == WAIT_INTR);
   assign timeout = busy && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

   // Watchdog: restarts on every state change, counts while a transaction is open
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                   tmo_cnt <= '0;
      else if (state_nxt != state) tmo_cnt <= '0;
      else if (busy)               tmo_cnt <= tmo_cnt + TW'(1);
   end
`else
   assign timeout = 1'b0;
`endif

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (!empty) begin
               case (head_op)
                  2'b00:   state_nxt = WR;
                  2'b01:   state_nxt = RD_ADDR;
                  2'b10:   state_nxt = WAIT_INTR;
                  default: state_nxt = RSP;
               endcase
            end
         end
         WR: begin
            if (timeout) state_nxt = RSP;
            else if ((aw_done || m_axi.awready) && (w_done || m_axi.wready)) state_nxt = WR_RESP;
         end
         WR_RESP:   if (timeout || m_axi.bvalid)  state_nxt = RSP;
         RD_ADDR: begin
            if (timeout)            state_nxt = RSP;
            else if (m_axi.arready) state_nxt = RD_DATA;
         end
         RD_DATA:   if (timeout || m_axi.rvalid) state_nxt = RSP;
         WAIT_INTR: if (timeout || intr_rise)    state_nxt = RSP;
         RSP:       if (rsp_ready)               state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Bus and response-valid outputs, decoded from state so reset drops them at once
   always_comb begin
      m_axi.awaddr  = addr_q;
      m_axi.awvalid = (state == WR) && !aw_done;
      m_axi.wdata   = wdata_q;
      m_axi.wstrb   = '1;
      m_axi.wvalid  = (state == WR) && !w_done;
      m_axi.bready  = (state == WR_RESP);
      m_axi.araddr  = addr_q;
      m_axi.arvalid = (state == RD_ADDR);
      m_axi.rready  = (state == RD_DATA);
      rsp_valid     = (state == RSP);
   end

   // Command capture on pop, per-channel handshake tracking, response capture
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cur_op   <= 2'b00;
         addr_q   <= '0;
         wdata_q  <= '0;
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
         rsp_op   <= 2'b00;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
      end else if (pop) begin
         cur_op  <= head_op;
         addr_q  <= head_addr;
         wdata_q <= head_wdata;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         if (head_op == 2'b11) begin
            rsp_op   <= 2'b11;
            rsp_data <= '0;
            rsp_err  <= 1'b1;
         end
      end else if (timeout) begin
         rsp_op   <= cur_op;
         rsp_data <= '0;
         rsp_err  <= 1'b1;
      end else begin
         case (state)
            WR: begin
               if (m_axi.awvalid && m_axi.awready) aw_done <= 1'b1;
               if (m_axi.wvalid && m_axi.wready)   w_done  <= 1'b1;
            end
            WR_RESP: if (m_axi.bvalid) begin
               rsp_op   <= cur_op;
               rsp_data <= '0;
               rsp_err  <= |m_axi.bresp;
            end
            RD_DATA: if (m_axi.rvalid) begin
               rsp_op   <= cur_op;
               rsp_data <= m_axi.rdata;
               rsp_err  <= |m_axi.rresp;
            end
            WAIT_INTR: if (intr_rise) begin
               rsp_op   <= cur_op;
               rsp_data <= '0;
               rsp_err  <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_zynet_axil_master.sv
// Bench for zynet_axil_master: reactive AXI-lite slave model plus a response
// scoreboard; each scenario is one task called from the main initial block.
module tb_zynet_axil_master;
   localparam int AW = 32;
   localparam int DW = 32;

   typedef struct {
      logic [1:0]    op;
      logic [DW-1:0] data;
      logic          err;
   } rsp_t;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = 2'b00;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [1:0]    rsp_op;
   logic [DW-1:0] rsp_data;
   logic          rsp_err;
   logic          intr = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   rsp_t          exp_q[$];
   logic [AW-1:0] wr_log_addr[$];
   logic [DW-1:0] wr_log_data[$];

   // slave knobs, changed by the tasks on falling edges
   logic          slv_aw_rdy = 1'b1;
   logic          slv_w_rdy  = 1'b1;
   int            slv_ar_delay = 0;
   logic [DW-1:0] slv_rdata = '0;
   logic [1:0]    slv_rresp = 2'b00;
   logic [1:0]    slv_bresp = 2'b00;

   int            ar_cnt;
   logic          aw_got, w_got;
   logic [AW-1:0] aw_lat;
   logic [DW-1:0] w_lat;

   zynet_axil_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

   zynet_axil_master #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(16)
   ) dut (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .intr(intr),
      .m_axi(axi)
   );

   always #5 clock = ~clock;

   assign axi.awready = slv_aw_rdy;
   assign axi.wready  = slv_w_rdy;
   assign axi.arready = axi.arvalid && (ar_cnt == slv_ar_delay);

   // slave write channel: B response one cycle after both AW and W are taken
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         axi.bvalid <= 1'b0;
         axi.bresp  <= 2'b00;
         aw_got     <= 1'b0;
         w_got      <= 1'b0;
         aw_lat     <= '0;
         w_lat      <= '0;
      end else begin
         if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
         if ((aw_got || (axi.awvalid && axi.awready)) && (w_got || (axi.wvalid && axi.wready))) begin
            axi.bvalid <= 1'b1;
            axi.bresp  <= slv_bresp;
            aw_got     <= 1'b0;
            w_got      <= 1'b0;
            wr_log_addr.push_back(aw_got ? aw_lat : axi.awaddr);
            wr_log_data.push_back(w_got ? w_lat : axi.wdata);
         end else begin
            if (axi.awvalid && axi.awready) begin aw_got <= 1'b1; aw_lat <= axi.awaddr; end
            if (axi.wvalid && axi.wready)   begin w_got  <= 1'b1; w_lat  <= axi.wdata;  end
         end
      end
   end

   // slave read channel: arready after slv_ar_delay cycles, R one cycle later
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         ar_cnt     <= 0;
         axi.rvalid <= 1'b0;
         axi.rdata  <= '0;
         axi.rresp  <= 2'b00;
      end else begin
         if (axi.arvalid && !axi.arready) ar_cnt <= ar_cnt + 1;
         else                             ar_cnt <= 0;
         if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
         if (axi.arvalid && axi.arready) begin
            axi.rvalid <= 1'b1;
            axi.rdata  <= slv_rdata;
            axi.rresp  <= slv_rresp;
         end
      end
   end

   task automatic push_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] exp_data,
                           input logic exp_err);
      rsp_t e;
      int   w;
      @(negedge clock);
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wdata;
      w = 0;
      while (!cmd_ready && w < 200) begin @(negedge clock); w++; end
      if (!cmd_ready) begin
         n_checks++; n_fail++;
         $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, w);
      end else begin
         e.op = op; e.data = exp_data; e.err = exp_err;
         exp_q.push_back(e);
         @(posedge clock);
      end
      @(negedge clock);
      cmd_valid = 1'b0;
   endtask

   task automatic collect_rsp(input int n);
      rsp_t e;
      int   got = 0;
      int   waited = 0;
      while (got < n && waited < 2000) begin
         @(negedge clock);
         rsp_ready = 1'b0;
         waited++;
         if (rsp_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL rsp_unexpected: op=%0d data=%h err=%b, required no response", rsp_op, rsp_data, rsp_err);
            end else begin
               e = exp_q.pop_front();
               if (rsp_op !== e.op || rsp_data !== e.data || rsp_err !== e.err) begin
                  n_fail++;
                  $display("FAIL rsp_fields: got op=%0d data=%h err=%b, required op=%0d data=%h err=%b",
                           rsp_op, rsp_data, rsp_err, e.op, e.data, e.err);
               end
            end
            rsp_ready = 1'b1;
            got++;
         end
      end
      @(negedge clock);
      rsp_ready = 1'b0;
      if (got < n) begin
         n_checks++; n_fail++;
         $display("FAIL rsp_timeout: got %0d responses, required %0d", got, n);
      end
   endtask

   task automatic test_reset();
      @(negedge clock);
      n_checks++;
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_ready_valid: cmd_ready=%b rsp_valid=%b, required 0 0", cmd_ready, rsp_valid);
      end
      n_checks++;
      if (rsp_data !== '0 || rsp_err !== 1'b0 || rsp_op !== 2'b00) begin
         n_fail++; $display("FAIL reset_rsp_fields: data=%h err=%b op=%0d, required 0", rsp_data, rsp_err, rsp_op);
      end
      n_checks++;
      if ({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready} !== 5'b0 ||
          axi.awaddr !== '0 || axi.araddr !== '0 || axi.wdata !== '0) begin
         n_fail++; $display("FAIL reset_axi: aw=%b w=%b b=%b ar=%b r=%b awaddr=%h, required all 0",
                            axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, axi.awaddr);
      end
      reset = 1'b0;
      @(negedge clock);
      n_checks++;
      if (cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_release_ready: cmd_ready=%b, required 1", cmd_ready);
      end
   endtask

   task automatic test_write();
      int w = 0;
      push_cmd(2'b00, 32'h0C, 32'h1, '0, 1'b0);
      while (!axi.awvalid && w < 50) begin @(negedge clock); w++; end
      n_checks++;
      if (!(axi.awvalid && axi.awready && axi.wvalid && axi.wready) ||
          axi.awaddr !== 32'h0C || axi.wdata !== 32'h1 || axi.wstrb !== 4'hF) begin
         n_fail++; $display("FAIL wr_handshake: awv=%b wv=%b awaddr=%h wdata=%h wstrb=%h, required 1 1 0c 1 f",
                            axi.awvalid, axi.wvalid, axi.awaddr, axi.wdata, axi.wstrb);
      end
      @(negedge clock);
      n_checks++;
      if (rsp_valid !== 1'b0 || axi.awvalid !== 1'b0 || axi.bready !== 1'b1) begin
         n_fail++; $display("FAIL wr_resp_phase: rsp_valid=%b awvalid=%b bready=%b, required 0 0 1", rsp_valid, axi.awvalid, axi.bready);
      end
      @(negedge clock);
      n_checks++;
      if (rsp_valid !== 1'b1) begin
         n_fail++; $display("FAIL wr_latency: rsp_valid=%b two cycles after pop, required 1", rsp_valid);
      end
      collect_rsp(1);
   endtask

   task automatic test_read();
      int w = 0;
      int stall = 0;
      slv_ar_delay = 3; slv_rdata = 32'h7; slv_rresp = 2'b00;
      push_cmd(2'b01, 32'h08, '0, 32'h7, 1'b0);
      while (!axi.arvalid && w < 50) begin @(negedge clock); w++; end
      n_checks++;
      if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h08) begin
         n_fail++; $display("FAIL rd_addr: arvalid=%b araddr=%h, required 1 08", axi.arvalid, axi.araddr);
      end
      while (axi.arvalid && !axi.arready && stall < 20) begin @(negedge clock); stall++; end
      n_checks++;
      if (stall != 3 || axi.arvalid !== 1'b1) begin
         n_fail++; $display("FAIL rd_arvalid_hold: held %0d cycles before arready (arvalid=%b), required 3 (1)", stall, axi.arvalid);
      end
      collect_rsp(1);
      slv_ar_delay = 0;
   endtask

   task automatic test_errors();
      slv_bresp = 2'b10;
      push_cmd(2'b00, 32'h10, 32'h55, '0, 1'b1);
      collect_rsp(1);
      slv_bresp = 2'b00;
      slv_rdata = 32'hDEAD; slv_rresp = 2'b11;
      push_cmd(2'b01, 32'h14, '0, 32'hDEAD, 1'b1);
      collect_rsp(1);
      slv_rresp = 2'b00;
      push_cmd(2'b11, 32'h18, '0, '0, 1'b1);
      collect_rsp(1);
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] ea[$];
      logic [DW-1:0] ed[$];
      wr_log_addr.delete(); wr_log_data.delete();
      slv_aw_rdy = 1'b0; slv_w_rdy = 1'b0;
      // first write parks in the bus phase, the next eight fill the queue
      for (int i = 0; i < 9; i++) begin
         ea.push_back(32'h100 + 32'(4 * i));
         ed.push_back(32'hA0 + 32'(i));
         push_cmd(2'b00, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), '0, 1'b0);
      end
      n_checks++;
      if (cmd_ready !== 1'b0) begin
         n_fail++; $display("FAIL fifo_full_ready: cmd_ready=%b with queue full, required 0", cmd_ready);
      end
      slv_aw_rdy = 1'b1; slv_w_rdy = 1'b1;
      collect_rsp(9);
      n_checks++;
      if (wr_log_addr.size() != 9) begin
         n_fail++; $display("FAIL fifo_count: %0d writes on bus, required 9", wr_log_addr.size());
      end else begin
         for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (wr_log_addr[i] !== ea[i] || wr_log_data[i] !== ed[i]) begin
               n_fail++; $display("FAIL fifo_order[%0d]: addr=%h data=%h, required addr=%h data=%h",
                                  i, wr_log_addr[i], wr_log_data[i], ea[i], ed[i]);
            end
         end
      end
   endtask

   task automatic test_intr();
      @(negedge clock);
      intr = 1'b1;
      push_cmd(2'b10, '0, '0, '0, 1'b0);
      repeat (10) @(negedge clock);
      n_checks++;
      if (rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL intr_level_ignored: rsp_valid=%b with intr held high, required 0", rsp_valid);
      end
      intr = 1'b0;
      repeat (2) @(negedge clock);
      n_checks++;
      if (rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL intr_low_wait: rsp_valid=%b with intr low, required 0", rsp_valid);
      end
      intr = 1'b1;
      @(negedge clock);
      n_checks++;
      if (rsp_valid !== 1'b1) begin
         n_fail++; $display("FAIL intr_rise_rsp: rsp_valid=%b cycle after rising intr, required 1", rsp_valid);
      end
      collect_rsp(1);
      intr = 1'b0;
   endtask

   task automatic test_timeout();
      int w = 0;
      slv_aw_rdy = 1'b0; slv_w_rdy = 1'b0;
`ifdef ZYNET_AXIL_TIMEOUT_EN
      push_cmd(2'b00, 32'h20, 32'h3, '0, 1'b1);
      while (!axi.awvalid && w < 50) begin @(negedge clock); w++; end
      repeat (15) @(negedge clock);
      n_checks++;
      if (rsp_valid !== 1'b0 || axi.wvalid !== 1'b1) begin
         n_fail++; $display("FAIL tmo_early: rsp_valid=%b wvalid=%b at cycle 15, required 0 1", rsp_valid, axi.wvalid);
      end
      @(negedge clock);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || axi.awvalid !== 1'b0 || axi.wvalid !== 1'b0) begin
         n_fail++; $display("FAIL tmo_abort: rsp_valid=%b rsp_err=%b awvalid=%b wvalid=%b at cycle 16, required 1 1 0 0",
                            rsp_valid, rsp_err, axi.awvalid, axi.wvalid);
      end
      collect_rsp(1);
      slv_aw_rdy = 1'b1; slv_w_rdy = 1'b1;
`else
      push_cmd(2'b00, 32'h20, 32'h3, '0, 1'b0);
      while (!axi.awvalid && w < 50) begin @(negedge clock); w++; end
      repeat (40) @(negedge clock);
      n_checks++;
      if (rsp_valid !== 1'b0 || axi.awvalid !== 1'b1 || axi.wvalid !== 1'b1) begin
         n_fail++; $display("FAIL stall_wait: rsp_valid=%b awvalid=%b wvalid=%b after 40 stalled cycles, required 0 1 1",
                            rsp_valid, axi.awvalid, axi.wvalid);
      end
      slv_aw_rdy = 1'b1; slv_w_rdy = 1'b1;
      collect_rsp(1);
`endif
   endtask

   task automatic test_reset_mid_read();
      int   w = 0;
      logic busy_seen = 1'b0;
      slv_ar_delay = 50;
      push_cmd(2'b01, 32'h08, '0, '0, 1'b0);
      push_cmd(2'b00, 32'h30, 32'h1, '0, 1'b0);
      push_cmd(2'b01, 32'h34, '0, '0, 1'b0);
      while (!axi.arvalid && w < 50) begin @(negedge clock); w++; end
      n_checks++;
      if (axi.arvalid !== 1'b1) begin
         n_fail++; $display("FAIL rst_pre_arvalid: arvalid=%b before reset, required 1", axi.arvalid);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if (axi.arvalid !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
         n_fail++; $display("FAIL rst_immediate: arvalid=%b rsp_valid=%b cmd_ready=%b, required 0 0 0",
                            axi.arvalid, rsp_valid, cmd_ready);
      end
      exp_q.delete();
      slv_ar_delay = 0;
      @(negedge clock);
      reset = 1'b0;
      repeat (10) begin
         @(negedge clock);
         if (axi.arvalid || axi.awvalid || rsp_valid) busy_seen = 1'b1;
      end
      n_checks++;
      if (busy_seen !== 1'b0 || cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL rst_fifo_empty: activity=%b cmd_ready=%b after release, required 0 1", busy_seen, cmd_ready);
      end
      slv_rdata = 32'h1234;
      push_cmd(2'b01, 32'h40, '0, 32'h1234, 1'b0);
      collect_rsp(1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write();
      test_read();
      test_errors();
      test_back_to_back();
      test_intr();
      test_timeout();
      test_reset_mid_read();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
